// File: rtl/i2c_port_arbiter.sv
// rtl/i2c_port_arbiter.sv - round-robin arbiter sharing one I2C byte master between two register requesters
module i2c_port_arbiter #(
  parameter int GAP_CYCLES     = 50,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_req,
  input  logic       a_wr,
  input  logic [7:0] a_add,
  input  logic [7:0] a_wdat,
  output logic [7:0] a_rdat,
  output logic       a_done,
  output logic       a_err,
  input  logic       b_req,
  input  logic       b_wr,
  input  logic [7:0] b_add,
  input  logic [7:0] b_wdat,
  output logic [7:0] b_rdat,
  output logic       b_done,
  output logic       b_err,
  output logic       write_start,
  output logic [7:0] write_add,
  output logic [7:0] write_dat,
  input  logic       write_over,
  output logic       read_start,
  output logic [7:0] read_add,
  input  logic       read_over,
  input  logic [7:0] read_dat,
  output logic       busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_GAP} state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;
  localparam logic [23:0] TMO_LAST = 24'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  GAP_LAST = 8'(GAP_CYCLES - 1);

  state_t      state_q, state_d;
  logic        last_gnt_q, last_gnt_d;
  logic        gnt_q, gnt_d;
  logic        cur_wr_q, cur_wr_d;
  logic        over_d_q, over_d_d;
  logic [23:0] timer_q, timer_d;
  logic [7:0]  gap_q, gap_d;
  logic        write_start_q, write_start_d;
  logic        read_start_q, read_start_d;
  logic [7:0]  write_add_q, write_add_d;
  logic [7:0]  write_dat_q, write_dat_d;
  logic [7:0]  read_add_q, read_add_d;
  logic [7:0]  a_rdat_q, a_rdat_d;
  logic [7:0]  b_rdat_q, b_rdat_d;
  logic        a_done_q, a_done_d;
  logic        a_err_q, a_err_d;
  logic        b_done_q, b_done_d;
  logic        b_err_q, b_err_d;
  logic        busy_q, busy_d;

  logic        over_sel;
  logic        over_rise;
  logic        pick_b;
  logic        sel_wr;
  logic [7:0]  sel_add;
  logic [7:0]  sel_wdat;

  // Next-state and next-output computation for the IDLE/WAIT/GAP sequencer
  always_comb begin
    state_d       = state_q;
    last_gnt_d    = last_gnt_q;
    gnt_d         = gnt_q;
    cur_wr_d      = cur_wr_q;
    timer_d       = timer_q;
    gap_d         = gap_q;
    write_start_d = write_start_q;
    read_start_d  = read_start_q;
    write_add_d   = write_add_q;
    write_dat_d   = write_dat_q;
    read_add_d    = read_add_q;
    a_rdat_d      = a_rdat_q;
    b_rdat_d      = b_rdat_q;
    a_done_d      = 1'b0;
    a_err_d       = 1'b0;
    b_done_d      = 1'b0;
    b_err_d       = 1'b0;
    busy_d        = busy_q;

    // Only the direction currently in flight is watched; the other over is ignored.
    over_sel  = cur_wr_q ? write_over : read_over;
    over_rise = over_sel & ~over_d_q;
    over_d_d  = over_sel;

    // On a tie the port that was not served last wins.
    pick_b   = b_req & (~a_req | (last_gnt_q == PORT_A));
    sel_wr   = pick_b ? b_wr   : a_wr;
    sel_add  = pick_b ? b_add  : a_add;
    sel_wdat = pick_b ? b_wdat : a_wdat;

    unique case (state_q)
      ST_IDLE: begin
        if (a_req | b_req) begin
          gnt_d      = pick_b;
          last_gnt_d = pick_b;
          cur_wr_d   = sel_wr;
          if (sel_wr) begin
            write_add_d   = sel_add;
            write_dat_d   = sel_wdat;
            write_start_d = 1'b1;
          end else begin
            read_add_d   = sel_add;
            read_start_d = 1'b1;
          end
          // Track the new direction from the grant edge so a level already high
          // on entry to WAIT is not mistaken for a completion edge.
          over_d_d = sel_wr ? write_over : read_over;
          timer_d  = '0;
          busy_d   = 1'b1;
          state_d  = ST_WAIT;
        end
      end

      ST_WAIT: begin
        timer_d = timer_q + 24'd1;
        if (over_rise) begin
          write_start_d = 1'b0;
          read_start_d  = 1'b0;
          if (gnt_q == PORT_B) begin
            b_done_d = 1'b1;
            if (!cur_wr_q) b_rdat_d = read_dat;
          end else begin
            a_done_d = 1'b1;
            if (!cur_wr_q) a_rdat_d = read_dat;
          end
          gap_d   = '0;
          state_d = ST_GAP;
        end else if (timer_q == TMO_LAST) begin
          write_start_d = 1'b0;
          read_start_d  = 1'b0;
          if (gnt_q == PORT_B) begin
            b_done_d = 1'b1;
            b_err_d  = 1'b1;
          end else begin
            a_done_d = 1'b1;
            a_err_d  = 1'b1;
          end
          gap_d   = '0;
          state_d = ST_GAP;
        end
      end

      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end

      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset returns everything to idle with B as last grant
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      last_gnt_q    <= PORT_B;
      gnt_q         <= PORT_A;
      cur_wr_q      <= 1'b0;
      over_d_q      <= 1'b0;
      timer_q       <= '0;
      gap_q         <= '0;
      write_start_q <= 1'b0;
      read_start_q  <= 1'b0;
      write_add_q   <= '0;
      write_dat_q   <= '0;
      read_add_q    <= '0;
      a_rdat_q      <= '0;
      b_rdat_q      <= '0;
      a_done_q      <= 1'b0;
      a_err_q       <= 1'b0;
      b_done_q      <= 1'b0;
      b_err_q       <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_gnt_q    <= last_gnt_d;
      gnt_q         <= gnt_d;
      cur_wr_q      <= cur_wr_d;
      over_d_q      <= over_d_d;
      timer_q       <= timer_d;
      gap_q         <= gap_d;
      write_start_q <= write_start_d;
      read_start_q  <= read_start_d;
      write_add_q   <= write_add_d;
      write_dat_q   <= write_dat_d;
      read_add_q    <= read_add_d;
      a_rdat_q      <= a_rdat_d;
      b_rdat_q      <= b_rdat_d;
      a_done_q      <= a_done_d;
      a_err_q       <= a_err_d;
      b_done_q      <= b_done_d;
      b_err_q       <= b_err_d;
      busy_q        <= busy_d;
    end
  end

  assign write_start = write_start_q;
  assign write_add   = write_add_q;
  assign write_dat   = write_dat_q;
  assign read_start  = read_start_q;
  assign read_add    = read_add_q;
  assign a_rdat      = a_rdat_q;
  assign b_rdat      = b_rdat_q;
  assign a_done      = a_done_q;
  assign a_err       = a_err_q;
  assign b_done      = b_done_q;
  assign b_err       = b_err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_i2c_port_arbiter.sv
// tb/tb_i2c_port_arbiter.sv - scoreboard bench for i2c_port_arbiter
module tb_i2c_port_arbiter;

  localparam int GAP = 4;
  localparam int TMO = 100;

  logic       clk;
  logic       rst;
  logic       a_req, a_wr, b_req, b_wr;
  logic [7:0] a_add, a_wdat, b_add, b_wdat;
  logic [7:0] a_rdat, b_rdat;
  logic       a_done, a_err, b_done, b_err;
  logic       write_start, read_start, write_over, read_over, busy;
  logic [7:0] write_add, write_dat, read_add, read_dat;

  i2c_port_arbiter #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_wr(a_wr), .a_add(a_add), .a_wdat(a_wdat),
    .a_rdat(a_rdat), .a_done(a_done), .a_err(a_err),
    .b_req(b_req), .b_wr(b_wr), .b_add(b_add), .b_wdat(b_wdat),
    .b_rdat(b_rdat), .b_done(b_done), .b_err(b_err),
    .write_start(write_start), .write_add(write_add), .write_dat(write_dat),
    .write_over(write_over),
    .read_start(read_start), .read_add(read_add), .read_over(read_over),
    .read_dat(read_dat), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       port;
    logic       wr;
    logic [7:0] add;
    logic [7:0] wdat;
    logic [7:0] rdat;
    logic       err;
    logic       chk_gap;
  } txn_t;

  txn_t       exp_q[$];
  txn_t       mon_e;
  logic [7:0] model_rdat [2];
  int         n_checks = 0;
  int         n_fail   = 0;

  // master model controls
  int         m_delay  = 3;
  logic       m_hang   = 1'b0;
  logic       m_manual = 1'b0;
  logic       m_man_over = 1'b0;
  logic [7:0] m_rdata  = 8'h00;
  int         m_cnt    = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic push_exp(input logic port, input logic wr, input logic [7:0] add,
                          input logic [7:0] wdat, input logic [7:0] rdat,
                          input logic err, input logic chk_gap);
    txn_t t;
    t.port = port; t.wr = wr; t.add = add; t.wdat = wdat;
    t.rdat = rdat; t.err = err; t.chk_gap = chk_gap;
    exp_q.push_back(t);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(a_done | b_done) && n < budget);
    if (!(a_done | b_done)) check_eq("wait_done_timeout", 0, 1);
  endtask

  task automatic settle();
    repeat (GAP + 3) @(negedge clk);
  endtask

  // I2C master model: raises the in-flight over after m_delay cycles, drops it when start drops
  initial begin
    read_over  = 1'b0;
    write_over = 1'b0;
    read_dat   = 8'h00;
    forever begin
      @(negedge clk);
      #1;
      read_dat = m_rdata;
      if (m_manual) begin
        read_over  = m_man_over;
        write_over = 1'b0;
      end else if (read_start || write_start) begin
        if (!m_hang) begin
          m_cnt++;
          if (m_cnt >= m_delay) begin
            if (read_start) read_over = 1'b1;
            else write_over = 1'b1;
          end
        end
      end else begin
        m_cnt      = 0;
        read_over  = 1'b0;
        write_over = 1'b0;
      end
    end
  end

  // Scoreboard monitor: start rises and done pulses are matched against the expected queue
  int   cyc = 0;
  int   last_done_cyc = 0;
  int   rd_len = 0;
  int   wr_len = 0;
  logic prev_start = 1'b0;
  logic prev_a_done = 1'b0;
  logic prev_b_done = 1'b0;

  always begin
    @(negedge clk);
    #2;
    if (rst) begin
      exp_q.delete();
      model_rdat[0] = 8'h00;
      model_rdat[1] = 8'h00;
      prev_start  = 1'b0;
      prev_a_done = 1'b0;
      prev_b_done = 1'b0;
    end else begin
      cyc++;
      if ((read_start | write_start) && !prev_start) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_start", 1, 0);
        end else begin
          mon_e = exp_q[0];
          check_eq("start_dir", {write_start, read_start}, mon_e.wr ? 2'b10 : 2'b01);
          check_eq("start_add", mon_e.wr ? write_add : read_add, mon_e.add);
          if (mon_e.wr) check_eq("start_wdat", write_dat, mon_e.wdat);
          if (mon_e.chk_gap) check_eq("gap_cycles", cyc - last_done_cyc, GAP + 1);
        end
        rd_len = 0;
        wr_len = 0;
      end
      if (read_start) rd_len++;
      if (write_start) wr_len++;
      if (prev_a_done) check_eq("a_done_width", a_done, 0);
      if (prev_b_done) check_eq("b_done_width", b_done, 0);
      if (a_done | b_done) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_done", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check_eq("done_port", {b_done, a_done}, mon_e.port ? 2'b10 : 2'b01);
          check_eq("done_err", {b_err, a_err},
                   mon_e.err ? (mon_e.port ? 2'b10 : 2'b01) : 2'b00);
          if (!mon_e.wr && !mon_e.err) model_rdat[mon_e.port] = mon_e.rdat;
          check_eq("a_rdat", a_rdat, model_rdat[0]);
          check_eq("b_rdat", b_rdat, model_rdat[1]);
          check_eq("start_off_at_done", read_start | write_start, 0);
          check_eq("wrong_dir_start", mon_e.wr ? rd_len : wr_len, 0);
          if (mon_e.err) check_eq("timeout_start_len", mon_e.wr ? wr_len : rd_len, TMO);
        end
        last_done_cyc = cyc;
      end
      prev_start  = read_start | write_start;
      prev_a_done = a_done;
      prev_b_done = b_done;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  int dcount;
  logic p;

  initial begin
    rst = 1'b1;
    a_req = 1'b0; a_wr = 1'b0; a_add = 8'h00; a_wdat = 8'h00;
    b_req = 1'b0; b_wr = 1'b0; b_add = 8'h00; b_wdat = 8'h00;
    repeat (3) @(negedge clk);
    check_eq("rst_starts", {write_start, read_start}, 2'b00);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_adds", {write_add, write_dat, read_add}, 24'h0);
    check_eq("rst_rdat", {a_rdat, b_rdat}, 16'h0);
    check_eq("rst_done_err", {a_done, a_err, b_done, b_err}, 4'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // single read on A
    m_delay = 10; m_rdata = 8'h23;
    push_exp(1'b0, 1'b0, 8'h02, 8'h00, 8'h23, 1'b0, 1'b0);
    a_wr = 1'b0; a_add = 8'h02; a_req = 1'b1;
    @(negedge clk);
    check_eq("read_lat_start", read_start, 1);
    check_eq("read_lat_add", read_add, 8'h02);
    check_eq("read_lat_busy", busy, 1);
    wait_done(60);
    a_req = 1'b0;
    settle();

    // single write on B
    m_delay = 4; m_rdata = 8'hE7;
    push_exp(1'b1, 1'b1, 8'h0E, 8'h1C, 8'h00, 1'b0, 1'b0);
    b_wr = 1'b1; b_add = 8'h0E; b_wdat = 8'h1C; b_req = 1'b1;
    wait_done(60);
    check_eq("write_b_done", b_done, 1);
    b_req = 1'b0;
    settle();

    // both ports requesting continuously: A, B, A, B
    m_delay = 3; m_rdata = 8'h44;
    push_exp(1'b0, 1'b0, 8'h10, 8'h00, 8'h44, 1'b0, 1'b0);
    push_exp(1'b1, 1'b1, 8'h20, 8'h99, 8'h00, 1'b0, 1'b1);
    push_exp(1'b0, 1'b0, 8'h11, 8'h00, 8'h44, 1'b0, 1'b1);
    push_exp(1'b1, 1'b1, 8'h21, 8'h98, 8'h00, 1'b0, 1'b1);
    a_wr = 1'b0; a_add = 8'h10;
    b_wr = 1'b1; b_add = 8'h20; b_wdat = 8'h99;
    a_req = 1'b1; b_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_done(60);
      p = b_done;
      if (p) b_req = 1'b0; else a_req = 1'b0;
      @(negedge clk);
      if (i < 2) begin
        if (p) begin b_add = 8'h21; b_wdat = 8'h98; b_req = 1'b1; end
        else begin a_add = 8'h11; a_req = 1'b1; end
      end
    end
    settle();

    // timeout on A, then a normal read on B
    m_hang = 1'b1; m_rdata = 8'h55;
    push_exp(1'b0, 1'b0, 8'h05, 8'h00, 8'h00, 1'b1, 1'b0);
    a_wr = 1'b0; a_add = 8'h05; a_req = 1'b1;
    wait_done(TMO + 20);
    a_req = 1'b0;
    m_hang = 1'b0; m_rdata = 8'h66;
    push_exp(1'b1, 1'b0, 8'h06, 8'h00, 8'h66, 1'b0, 1'b0);
    b_wr = 1'b0; b_add = 8'h06; b_req = 1'b1;
    wait_done(60);
    b_req = 1'b0;
    settle();

    // stale over: read_over already high at grant
    m_manual = 1'b1; m_man_over = 1'b1; m_rdata = 8'h5A;
    @(negedge clk);
    push_exp(1'b0, 1'b0, 8'h07, 8'h00, 8'h5A, 1'b0, 1'b0);
    a_wr = 1'b0; a_add = 8'h07; a_req = 1'b1;
    dcount = 0;
    repeat (6) begin
      @(negedge clk);
      if (a_done) dcount++;
    end
    check_eq("stale_no_done", dcount, 0);
    m_man_over = 1'b0;
    repeat (2) @(negedge clk);
    m_man_over = 1'b1;
    @(negedge clk);
    check_eq("stale_rise_done", a_done, 1);
    a_req = 1'b0;
    @(negedge clk);
    m_man_over = 1'b0;
    settle();

    // over edge on the very timeout cycle
    m_rdata = 8'h3C;
    push_exp(1'b0, 1'b0, 8'h09, 8'h00, 8'h3C, 1'b0, 1'b0);
    a_wr = 1'b0; a_add = 8'h09; a_req = 1'b1;
    @(negedge clk);
    repeat (TMO - 1) @(negedge clk);
    m_man_over = 1'b1;
    @(negedge clk);
    check_eq("coinc_done", a_done, 1);
    check_eq("coinc_no_err", a_err, 0);
    a_req = 1'b0;
    @(negedge clk);
    m_man_over = 1'b0;
    @(negedge clk);
    m_manual = 1'b0;
    settle();

    // reset during WAIT on an A grant, then a tie must still go to A
    m_hang = 1'b1;
    push_exp(1'b0, 1'b0, 8'h33, 8'h00, 8'h00, 1'b0, 1'b0);
    a_wr = 1'b0; a_add = 8'h33; a_req = 1'b1;
    repeat (6) @(negedge clk);
    rst = 1'b1; a_req = 1'b0;
    @(negedge clk);
    check_eq("midrst_starts", {write_start, read_start}, 2'b00);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_done", {a_done, a_err, b_done, b_err}, 4'h0);
    check_eq("midrst_regs", {read_add, write_add, write_dat, a_rdat, b_rdat}, 40'h0);
    @(negedge clk);
    rst = 1'b0;
    m_hang = 1'b0; m_delay = 3; m_rdata = 8'h77;
    @(negedge clk);
    push_exp(1'b0, 1'b0, 8'h40, 8'h00, 8'h77, 1'b0, 1'b0);
    push_exp(1'b1, 1'b1, 8'h41, 8'h42, 8'h00, 1'b0, 1'b1);
    a_wr = 1'b0; a_add = 8'h40;
    b_wr = 1'b1; b_add = 8'h41; b_wdat = 8'h42;
    a_req = 1'b1; b_req = 1'b1;
    wait_done(60);
    check_eq("tie_after_reset_a", a_done, 1);
    a_req = 1'b0;
    wait_done(60);
    b_req = 1'b0;
    settle();
    check_eq("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
